// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC/nPC fetch-address sequencer.
// Contents: address width and type, reset/increment defaults, FSM state
// encodings, the pending-redirect payload and a word-alignment helper.
package pc_seq_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned STATE_W = 2;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t RESET_PC_DEF = 32'h0000_0000;
  localparam addr_t INC_DEF      = 32'h0000_0004;

  // Sequencer states
  localparam logic [STATE_W-1:0] ST_RUN        = 2'd0;
  localparam logic [STATE_W-1:0] ST_STALL      = 2'd1;
  localparam logic [STATE_W-1:0] ST_STALL_PEND = 2'd2;

  // One captured redirect waiting for the pipeline to advance
  typedef struct packed {
    logic  valid;
    addr_t target;
    logic  annul;
  } redir_t;

  // Fetch addresses are word aligned; low two target bits are dropped
  function automatic addr_t align_word(input addr_t a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/redirect_buffer.sv
// Single-entry pending-redirect buffer.
// Holds a redirect (target, annul) that arrived while the pipeline was
// stalled. clear_i has priority over capture_i.
// Build option: PCSEQ_ANNUL_EN -- when undefined no annul bit is stored and
// annul_o is tied low.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   capture_i        load target_i/annul_i and set valid
//   clear_i          drop the held entry
//   target_i         redirect target (already word aligned by the caller)
//   annul_i          delay-slot annul qualifier
//   entry_o          held entry (valid, target, annul)
module redirect_buffer
  import pc_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              capture_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              annul_i,
  output redir_t            entry_o
);

  logic        valid_q;
  logic        valid_d;
  addr_t       target_q;
  addr_t       target_d;

  // Valid/target next state
  always_comb begin
    valid_d  = valid_q;
    target_d = target_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (capture_i) begin
      valid_d  = 1'b1;
      target_d = target_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      target_q <= target_d;
    end
  end

`ifdef PCSEQ_ANNUL_EN
  logic annul_q;
  logic annul_d;

  always_comb begin
    annul_d = annul_q;
    if (clear_i) begin
      annul_d = 1'b0;
    end else if (capture_i) begin
      annul_d = annul_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      annul_q <= 1'b0;
    end else begin
      annul_q <= annul_d;
    end
  end

  assign entry_o = '{valid: valid_q, target: target_q, annul: annul_q};
`else
  logic unused_annul;
  assign unused_annul = annul_i;
  assign entry_o = '{valid: valid_q, target: target_q, annul: 1'b0};
`endif

endmodule

// File: rtl/pc_npc_sequencer.sv
// Fetch-address sequencer for a delayed-branch pipeline.
// Holds the PC/nPC pair, advances it on every enabled cycle and applies ID
// redirects with one delay slot. A redirect seen while stalled is parked in
// a one-entry buffer and applied on the next advance; the first parked
// redirect wins and a parked redirect wins over a live one.
// Build option: PCSEQ_ANNUL_EN -- enables the delay-slot annul path
// (ANNUL_IN captured/applied, ANNUL_IF driven). Undefined: ANNUL_IF is 0.
// Ports:
//   CLK, RESET        clock, asynchronous active-high reset
//   LE                advance enable (0 = stall, PC/nPC hold)
//   TA, TA_VALID      redirect target and qualifier from ID
//   ANNUL_IN          delay slot of the redirecting instruction is annulled
//   PC, NPC           current and next fetch address
//   ANNUL_IF          instruction fetched at PC is squashed entering ID
//   REDIRECT_PENDING  a parked redirect awaits the next advance
module pc_npc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [ADDR_W-1:0] INC      = INC_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LE,
  input  logic [ADDR_W-1:0] TA,
  input  logic              TA_VALID,
  input  logic              ANNUL_IN,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] NPC,
  output logic              ANNUL_IF,
  output logic              REDIRECT_PENDING
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  addr_t              pc_q;
  addr_t              pc_d;
  addr_t              npc_q;
  addr_t              npc_d;
  logic               annul_q;
  logic               annul_d;

  logic               buf_capture;
  logic               buf_clear;
  logic               live_annul;
  redir_t             pend;

  logic               redir_sel;
  addr_t              target_sel;
  logic               annul_sel;

`ifdef PCSEQ_ANNUL_EN
  assign live_annul = ANNUL_IN;
`else
  logic unused_annul_in;
  assign unused_annul_in = ANNUL_IN;
  assign live_annul      = 1'b0;
`endif

  redirect_buffer u_redirect_buffer (
    .clk       (CLK),
    .rst       (RESET),
    .capture_i (buf_capture),
    .clear_i   (buf_clear),
    .target_i  (align_word(TA)),
    .annul_i   (live_annul),
    .entry_o   (pend)
  );

  // Parked redirect takes precedence over the live ID request
  always_comb begin
    redir_sel  = TA_VALID;
    target_sel = TA;
    annul_sel  = live_annul;
    if (pend.valid) begin
      redir_sel  = 1'b1;
      target_sel = pend.target;
      annul_sel  = pend.annul;
    end
  end

  // Next-state, PC/nPC and buffer control
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    npc_d       = npc_q;
    annul_d     = annul_q;
    buf_capture = 1'b0;
    buf_clear   = 1'b0;

    if (LE) begin
      pc_d      = npc_q;
      npc_d     = redir_sel ? align_word(target_sel) : ADDR_W'(npc_q + INC);
      annul_d   = redir_sel & annul_sel;
      state_d   = ST_RUN;
      buf_clear = (state_q == ST_STALL_PEND);
    end else begin
      case (state_q)
        ST_RUN, ST_STALL: begin
          if (TA_VALID) begin
            buf_capture = 1'b1;
            state_d     = ST_STALL_PEND;
          end else begin
            state_d = ST_STALL;
          end
        end
        ST_STALL_PEND: begin
          state_d = ST_STALL_PEND;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State and address registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      npc_q   <= ADDR_W'(RESET_PC + INC);
      annul_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      annul_q <= annul_d;
    end
  end

  assign PC               = pc_q;
  assign NPC              = npc_q;
  assign ANNUL_IF         = annul_q;
  assign REDIRECT_PENDING = (state_q == ST_STALL_PEND);

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// Directed bench for pc_npc_sequencer: table of per-cycle vectors plus a
// hand-written asynchronous-reset-in-STALL_PEND sequence.
module tb_pc_npc_sequencer;

`ifdef PCSEQ_ANNUL_EN
  localparam bit ANN_EN = 1'b1;
`else
  localparam bit ANN_EN = 1'b0;
`endif
  localparam int unsigned NVEC = 23;

  logic        CLK;
  logic        RESET;
  logic        LE;
  logic [31:0] TA;
  logic        TA_VALID;
  logic        ANNUL_IN;
  logic [31:0] PC;
  logic [31:0] NPC;
  logic        ANNUL_IF;
  logic        REDIRECT_PENDING;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        le;
    logic        tav;
    logic [31:0] ta;
    logic        ann;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        exp_ann;
    logic        pend;
  } vec_t;

  vec_t vecs [NVEC];

  pc_npc_sequencer dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .LE               (LE),
    .TA               (TA),
    .TA_VALID         (TA_VALID),
    .ANNUL_IN         (ANNUL_IN),
    .PC               (PC),
    .NPC              (NPC),
    .ANNUL_IF         (ANNUL_IF),
    .REDIRECT_PENDING (REDIRECT_PENDING)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input int step,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic check_all(input int step, input logic [31:0] pc,
                           input logic [31:0] npc, input logic ann,
                           input logic pend);
    check("PC", step, PC, pc);
    check("NPC", step, NPC, npc);
    check("ANNUL_IF", step, {31'd0, ANNUL_IF}, {31'd0, ann});
    check("REDIRECT_PENDING", step, {31'd0, REDIRECT_PENDING}, {31'd0, pend});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //          le  tav ta             ann  pc             npc            annul        pend
    vecs[0]  = '{1, 0, 32'h0,          0, 32'h4,         32'h8,         1'b0,        0};
    vecs[1]  = '{1, 0, 32'h0,          0, 32'h8,         32'hC,         1'b0,        0};
    vecs[2]  = '{1, 0, 32'h0,          0, 32'hC,         32'h10,        1'b0,        0};
    vecs[3]  = '{1, 1, 32'h100,        0, 32'h10,        32'h100,       1'b0,        0};
    vecs[4]  = '{1, 0, 32'h0,          0, 32'h100,       32'h104,       1'b0,        0};
    vecs[5]  = '{1, 1, 32'h200,        0, 32'h104,       32'h200,       1'b0,        0};
    vecs[6]  = '{1, 0, 32'h0,          0, 32'h200,       32'h204,       1'b0,        0};
    vecs[7]  = '{1, 1, 32'h280,        1, 32'h204,       32'h280,       ANN_EN,      0};
    vecs[8]  = '{1, 0, 32'h0,          0, 32'h280,       32'h284,       1'b0,        0};
    vecs[9]  = '{1, 1, 32'h1F0,        1, 32'h284,       32'h1F0,       ANN_EN,      0};
    vecs[10] = '{0, 0, 32'h0,          0, 32'h284,       32'h1F0,       ANN_EN,      0};
    vecs[11] = '{0, 1, 32'h300,        0, 32'h284,       32'h1F0,       ANN_EN,      1};
    vecs[12] = '{0, 1, 32'h400,        1, 32'h284,       32'h1F0,       ANN_EN,      1};
    vecs[13] = '{0, 0, 32'h0,          0, 32'h284,       32'h1F0,       ANN_EN,      1};
    vecs[14] = '{1, 1, 32'h500,        1, 32'h1F0,       32'h300,       1'b0,        0};
    vecs[15] = '{1, 0, 32'h0,          0, 32'h300,       32'h304,       1'b0,        0};
    vecs[16] = '{0, 1, 32'h3A1,        1, 32'h300,       32'h304,       1'b0,        1};
    vecs[17] = '{1, 0, 32'h0,          0, 32'h304,       32'h3A0,       ANN_EN,      0};
    vecs[18] = '{1, 0, 32'h0,          0, 32'h3A0,       32'h3A4,       1'b0,        0};
    vecs[19] = '{1, 1, 32'hFFFF_FFFC,  0, 32'h3A4,       32'hFFFF_FFFC, 1'b0,        0};
    vecs[20] = '{1, 0, 32'h0,          0, 32'hFFFF_FFFC, 32'h0,         1'b0,        0};
    vecs[21] = '{1, 1, 32'h203,        0, 32'h0,         32'h200,       1'b0,        0};
    vecs[22] = '{1, 0, 32'h0,          0, 32'h200,       32'h204,       1'b0,        0};

    RESET    = 1'b1;
    LE       = 1'b0;
    TA       = '0;
    TA_VALID = 1'b0;
    ANNUL_IN = 1'b0;
    #12;
    check_all(-1, 32'h0, 32'h4, 1'b0, 1'b0);

    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < int'(NVEC); i++) begin
      LE       = vecs[i].le;
      TA_VALID = vecs[i].tav;
      TA       = vecs[i].ta;
      ANNUL_IN = vecs[i].ann;
      @(posedge CLK);
      #1;
      check_all(i, vecs[i].pc, vecs[i].npc, vecs[i].exp_ann, vecs[i].pend);
      @(negedge CLK);
    end

    // Park a redirect, then reset asynchronously between clock edges
    LE       = 1'b0;
    TA_VALID = 1'b1;
    TA       = 32'h700;
    ANNUL_IN = 1'b1;
    @(posedge CLK);
    #1;
    check_all(100, 32'h200, 32'h204, 1'b0, 1'b1);
    #2;
    RESET = 1'b1;
    #1;
    check_all(101, 32'h0, 32'h4, 1'b0, 1'b0);
    TA_VALID = 1'b0;
    ANNUL_IN = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    LE    = 1'b1;
    @(posedge CLK);
    #1;
    check_all(102, 32'h4, 32'h8, 1'b0, 1'b0);
    @(negedge CLK);
    @(posedge CLK);
    #1;
    check_all(103, 32'h8, 32'hC, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_npc_sequencer.md
# pc_npc_sequencer

Fetch-address sequencer for the delayed-branch pipeline: holds the PC/nPC pair, advances it each enabled cycle, and applies redirects produced in ID by the target address generator with one-delay-slot semantics. It consumes the target address and the call/taken-branch qualifier from ID and drives the IF fetch address plus an annul flag for the delay slot. A one-entry pending buffer captures a redirect arriving while the pipeline is stalled and applies it on the next advance.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; nPC loads RESET_PC+4
- INC, 4, sequential increment applied to nPC
- CLK  in  1  single clock, rising edge
- RESET  in  1  asynchronous, active-high; clears all state immediately
- LE  in  1  advance enable; 0 = pipeline stalled, PC/nPC hold
- TA  in  32  target address from ID (CALL or taken branch)
- TA_VALID  in  1  ID instruction redirects this cycle (CALL_ID or BI_ID)
- ANNUL_IN  in  1  delay slot of the redirecting instruction is annulled
- PC  out  32  fetch address for IF
- NPC  out  32  next fetch address
- ANNUL_IF  out  1  instruction currently fetched at PC is to be squashed on entry to ID
- REDIRECT_PENDING  out  1  pending buffer holds an unapplied redirect

## Operation
- States: RUN, STALL, STALL_PEND. Reset state RUN.
- Advance (any state, LE=1): PC <= NPC; NPC <= redirect ? {T[31:2],2'b00} : NPC+INC; ANNUL_IF <= redirect & annul; next state RUN.
- Redirect source on advance: pending buffer if valid (STALL_PEND), else live TA/TA_VALID/ANNUL_IN. Pending wins over live.
- RUN, LE=0: TA_VALID=1 -> capture TA, ANNUL_IN into buffer, go STALL_PEND; else go STALL.
- STALL, LE=0: TA_VALID=1 -> capture, go STALL_PEND; else stay.
- STALL_PEND, LE=0: hold; live TA_VALID ignored (first captured redirect wins).
- Advancing from STALL_PEND clears the buffer in the same edge; REDIRECT_PENDING = (state==STALL_PEND).
- ANNUL_IF holds its value while LE=0; cleared by the next advance without annul.
- Arithmetic: all PC math 32-bit modulo 2^32; NPC=32'hFFFF_FFFC advances to 32'h0000_0000. TA[1:0] forced to 00.

## Timing
- Reset values: PC=RESET_PC, NPC=RESET_PC+4, ANNUL_IF=0, REDIRECT_PENDING=0, buffer cleared, state RUN.
- RESET asserted mid-operation: outputs reach reset values asynchronously, pending redirect discarded; first advance after release fetches RESET_PC+4.
- Redirect latency: TA_VALID sampled at edge N (LE=1) -> NPC=TA after N, PC=TA after edge N+1 (one delay slot fetched at old NPC).
- Redirect under stall: applied at first edge with LE=1; same delay-slot timing from that edge.
- All outputs registered; no combinational input-to-output path.

## Configuration
- PCSEQ_ANNUL_EN defined: ANNUL_IN captured/applied as above, ANNUL_IF driven.
- Not defined: ANNUL_IN ignored, buffer stores no annul bit, ANNUL_IF tied 0; all PC/nPC behaviour unchanged.

## Structure
- Package pc_seq_pkg: state enumeration (RUN, STALL, STALL_PEND), INC and RESET_PC defaults, 32-bit address type.
- One sub-module: redirect_buffer — single-entry register (valid, target, annul) with capture, clear, and async reset; the sequencer FSM and PC/nPC registers stay in the top.

## Test plan
- Reset release, LE=1 for 3 cycles -> PC 0,4,8,12; NPC 4,8,12,16; ANNUL_IF=0.
- PC=0x100, NPC=0x104, TA_VALID=1, TA=0x200, ANNUL_IN=0, LE=1 -> next PC=0x104/NPC=0x200, then PC=0x200/NPC=0x204.
- Same with ANNUL_IN=1 -> ANNUL_IF=1 while PC=0x104, 0 while PC=0x200 (macro defined); always 0 with macro undefined.
- LE=0, pulse TA_VALID with TA=0x300, then TA_VALID with TA=0x400 while still stalled -> REDIRECT_PENDING=1, PCs frozen; on LE=1 NPC=0x300, REDIRECT_PENDING=0.
- NPC=0xFFFF_FFFC, LE=1, no redirect -> PC=0xFFFF_FFFC, NPC=0x0000_0000; TA=0x0000_0203 -> NPC=0x0000_0200.
- RESET pulsed asynchronously in STALL_PEND -> PC=RESET_PC, NPC=RESET_PC+4, REDIRECT_PENDING=0 before next clock edge; pending target never applied.
